// File: rtl/score_entry_if.sv
// Handshake bundle for the score-entry converter: digit stream in, binary result out.
interface score_entry_if #(
    parameter int unsigned WIDTH = 12
);
    logic             start;
    logic             digit_valid;
    logic [3:0]       digit;
    logic             digit_ready;
    logic             o_valid;
    logic             o_ready;
    logic [WIDTH-1:0] o_score;
    logic             overflow;
    logic             bad_digit;

    modport master (
        output start, digit_valid, digit, o_ready,
        input  digit_ready, o_valid, o_score, overflow, bad_digit
    );

    modport slave (
        input  start, digit_valid, digit, o_ready,
        output digit_ready, o_valid, o_score, overflow, bad_digit
    );
endinterface

// File: rtl/score_entry.sv
// Sequential BCD-to-binary converter: acc = acc*10 + digit over NDIGITS digits,
// saturating at 2^WIDTH-1 with sticky overflow / bad-digit flags per number.
module score_entry #(
    parameter int unsigned NDIGITS = 4,
    parameter int unsigned WIDTH   = 12
) (
    input logic         clk,
    input logic         rst_n,
    score_entry_if.slave bus
);
    localparam int unsigned CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int unsigned ACC_W = WIDTH + 4;
    localparam logic [ACC_W-1:0] SAT = {4'b0000, {WIDTH{1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_overflow;
    logic               r_bad;
    logic               r_valid;
    logic               r_digit_ready;

    logic [WIDTH-1:0]   w_acc_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_overflow_nxt;
    logic               w_bad_nxt;
    logic               w_valid_nxt;
    logic               w_digit_ready_nxt;
    logic               w_xfer;
    logic               w_last;
    logic               w_start_ok;
    logic [3:0]         w_d_eff;
    logic [ACC_W-1:0]   w_acc_ext;
    logic [ACC_W-1:0]   w_sum;

    // start is honoured everywhere except DONE, where it needs the result taken
    assign w_xfer     = bus.digit_valid && (r_state == S_ACCUM);
    assign w_last     = (r_cnt == CNT_W'(NDIGITS - 1));
    assign w_start_ok = bus.start && ((r_state != S_DONE) || bus.o_ready);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_next_state = S_ACCUM;
            end
            S_ACCUM: begin
                if (!bus.start && w_xfer && w_last) w_next_state = S_DONE;
            end
            S_DONE: begin
                if (bus.o_ready) w_next_state = bus.start ? S_ACCUM : S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath and output next values; x10 as two shifts and an add
    always_comb begin
        w_acc_nxt         = r_acc;
        w_cnt_nxt         = r_cnt;
        w_overflow_nxt    = r_overflow;
        w_bad_nxt         = r_bad;
        w_d_eff           = (bus.digit > 4'd9) ? 4'd0 : bus.digit;
        w_acc_ext         = ACC_W'(r_acc);
        w_sum             = (w_acc_ext << 3) + (w_acc_ext << 1) + ACC_W'(w_d_eff);
        w_valid_nxt       = (w_next_state == S_DONE);
        w_digit_ready_nxt = (w_next_state == S_ACCUM);

        if (w_start_ok) begin
            w_acc_nxt      = '0;
            w_cnt_nxt      = '0;
            w_overflow_nxt = 1'b0;
            w_bad_nxt      = 1'b0;
        end else if (w_xfer) begin
            if (bus.digit > 4'd9) w_bad_nxt = 1'b1;
            if (w_sum > SAT) begin
                w_acc_nxt      = '1;
                w_overflow_nxt = 1'b1;
            end else begin
                w_acc_nxt = WIDTH'(w_sum);
            end
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    // Registered outputs and datapath state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc         <= '0;
            r_cnt         <= '0;
            r_overflow    <= 1'b0;
            r_bad         <= 1'b0;
            r_valid       <= 1'b0;
            r_digit_ready <= 1'b0;
        end else begin
            r_acc         <= w_acc_nxt;
            r_cnt         <= w_cnt_nxt;
            r_overflow    <= w_overflow_nxt;
            r_bad         <= w_bad_nxt;
            r_valid       <= w_valid_nxt;
            r_digit_ready <= w_digit_ready_nxt;
        end
    end

    assign bus.o_score     = r_acc;
    assign bus.overflow    = r_overflow;
    assign bus.bad_digit   = r_bad;
    assign bus.o_valid     = r_valid;
    assign bus.digit_ready = r_digit_ready;
endmodule

// File: tb/tb_score_entry.sv
// Scoreboard bench for score_entry: stimulus pushes expected results, a monitor
// pops and compares each result as o_valid rises and checks it stays stable.
module tb_score_entry;
    localparam int unsigned WIDTH = 12;

    typedef struct {
        logic [WIDTH-1:0] score;
        logic             ovf;
        logic             bad;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;
    int   n_cyc;
    int   t_start;
    exp_t q[$];

    score_entry_if #(.WIDTH(WIDTH)) bus ();

    score_entry #(.NDIGITS(4), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) n_cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] s, input logic o, input logic b);
        exp_t e;
        e.score = s;
        e.ovf   = o;
        e.bad   = b;
        q.push_back(e);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        t_start = n_cyc;
        chk("ready_after_start", 32'(bus.digit_ready), 32'd1);
    endtask

    task automatic send_digit(input logic [3:0] d, input int gap);
        logic ok;
        for (int i = 0; i < gap; i++) begin
            bus.digit_valid = 1'b0;
            cyc();
        end
        bus.digit_valid = 1'b1;
        bus.digit       = d;
        for (int t = 0; t < 30; t++) begin
            ok = bus.digit_ready;
            cyc();
            if (ok) break;
            if (t == 29) chk("digit_accept_timeout", 32'd0, 32'd1);
        end
        bus.digit_valid = 1'b0;
    endtask

    task automatic send_num(input logic [15:0] ds, input bit gaps);
        logic [15:0] v;
        v = ds;
        for (int i = 0; i < 4; i++) begin
            send_digit(v[15:12], gaps ? int'($urandom_range(0, 2)) : 0);
            v = v << 4;
        end
    endtask

    // Wait for result, hold it for `hold` cycles, then take it
    task automatic take(input int hold, input bit extra, input bit poke, input bit start_on_ack,
                        output int lat);
        int t;
        for (t = 0; t < 30 && !bus.o_valid; t++) cyc();
        if (!bus.o_valid) chk("result_timeout", 32'd0, 32'd1);
        lat = n_cyc - t_start + 1;
        for (int i = 0; i < hold; i++) begin
            bus.digit_valid = extra;
            bus.digit       = 4'd5;
            bus.start       = poke && (i == 2);
            cyc();
            bus.start = 1'b0;
        end
        bus.digit_valid = 1'b0;
        bus.o_ready     = 1'b1;
        bus.start       = start_on_ack;
        cyc();
        bus.o_ready = 1'b0;
        bus.start   = 1'b0;
        chk("valid_fall", 32'(bus.o_valid), 32'd0);
        chk("ready_after_ack", 32'(bus.digit_ready), 32'(start_on_ack));
    endtask

    // Monitor: compare on the first cycle of each result, then check it holds
    initial begin
        exp_t e;
        logic seen;
        logic [WIDTH-1:0] h_score;
        logic h_ovf, h_bad;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.o_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    h_score = bus.o_score;
                    h_ovf   = bus.overflow;
                    h_bad   = bus.bad_digit;
                    if (q.size() == 0) begin
                        chk("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("score", 32'(bus.o_score), 32'(e.score));
                        chk("overflow", 32'(bus.overflow), 32'(e.ovf));
                        chk("bad_digit", 32'(bus.bad_digit), 32'(e.bad));
                    end
                end else begin
                    chk("score_stable", 32'(bus.o_score), 32'(h_score));
                    chk("flags_stable", {30'd0, bus.overflow, bus.bad_digit}, {30'd0, h_ovf, h_bad});
                    chk("no_ready_in_done", 32'(bus.digit_ready), 32'd0);
                end
                if (bus.o_ready) seen = 1'b0;
            end
        end
    end

    initial begin
        int lat;
        n_checks = 0;
        n_err    = 0;
        n_cyc    = 0;
        t_start  = 0;
        bus.start       = 1'b0;
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
        bus.o_ready     = 1'b0;
        rst_n = 1'b0;
        #12;
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_ready", 32'(bus.digit_ready), 32'd0);
        chk("rst_score", 32'(bus.o_score), 32'd0);
        chk("rst_flags", {30'd0, bus.overflow, bus.bad_digit}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // 1234 back-to-back, minimum latency
        push(12'h4D2, 1'b0, 1'b0);
        do_start();
        send_num(16'h1234, 1'b0);
        take(0, 1'b0, 1'b0, 1'b0, lat);
        chk("latency", 32'(lat), 32'd5);

        push(12'hFFF, 1'b0, 1'b0);
        do_start();
        send_num(16'h4095, 1'b0);
        take(1, 1'b0, 1'b0, 1'b0, lat);

        push(12'hFFF, 1'b1, 1'b0);
        do_start();
        send_num(16'h4096, 1'b0);
        take(1, 1'b0, 1'b0, 1'b0, lat);

        // 9999 saturates; start with the ack goes straight into the next number
        push(12'hFFF, 1'b1, 1'b0);
        do_start();
        send_num(16'h9999, 1'b0);
        take(1, 1'b0, 1'b0, 1'b1, lat);

        push(12'h000, 1'b0, 1'b0);
        send_num(16'h0000, 1'b0);
        take(0, 1'b0, 1'b0, 1'b0, lat);

        // 1,A,3,F: bad digits count as zero -> 1030
        push(12'h406, 1'b0, 1'b1);
        do_start();
        send_num(16'h1A3F, 1'b0);
        take(0, 1'b0, 1'b0, 1'b0, lat);

        // 5678 exceeds 12 bits: saturates, bad_digit cleared by start
        push(12'hFFF, 1'b1, 1'b0);
        do_start();
        send_num(16'h5678, 1'b0);
        take(0, 1'b0, 1'b0, 1'b0, lat);

        // Gappy digits, long hold with extra digits offered in DONE
        push(12'h929, 1'b0, 1'b0);
        do_start();
        send_num(16'h2345, 1'b1);
        take(10, 1'b1, 1'b0, 1'b0, lat);

        // Restart mid-number; the digit alongside start is discarded
        push(12'd42, 1'b0, 1'b0);
        do_start();
        send_digit(4'd7, 0);
        send_digit(4'd7, 0);
        bus.start       = 1'b1;
        bus.digit_valid = 1'b1;
        bus.digit       = 4'd9;
        cyc();
        bus.start       = 1'b0;
        bus.digit_valid = 1'b0;
        chk("ready_after_restart", 32'(bus.digit_ready), 32'd1);
        send_num(16'h0042, 1'b0);
        take(5, 1'b0, 1'b1, 1'b0, lat);

        // Async reset mid-number with bad_digit already set
        do_start();
        send_digit(4'd9, 0);
        send_digit(4'hA, 0);
        chk("pre_reset_bad", 32'(bus.bad_digit), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.o_valid), 32'd0);
        chk("arst_ready", 32'(bus.digit_ready), 32'd0);
        chk("arst_score", 32'(bus.o_score), 32'd0);
        chk("arst_flags", {30'd0, bus.overflow, bus.bad_digit}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        push(12'h457, 1'b0, 1'b0);
        do_start();
        send_num(16'h1111, 1'b0);
        take(0, 1'b0, 1'b0, 1'b0, lat);

        for (int t = 0; t < 20 && q.size() != 0; t++) cyc();
        chk("results_outstanding", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
